// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline controller.
package pipe_ctrl_pkg;

    // Register index width of the ARM register file (r0..r15).
    localparam int REG_IDX_W = 4;

    // r15 is the PC; reads of it come from the fetch path, never from a
    // pipeline register, so they can never form a RAW hazard.
    localparam logic [REG_IDX_W-1:0] PC_REG = 4'd15;

    // Memory-wait FSM states.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    // Pipeline control bundle driven by the priority mux.
    typedef struct packed {
        logic freeze_if;
        logic flush_ifid;
        logic flush_idex;
        logic freeze_all;
    } pipe_ctrl_t;

    // True when a writing instruction targets a register that the ID stage
    // reads. Sources naming the PC are excluded.
    function automatic logic src_match(
        input logic                 wb_en,
        input logic [REG_IDX_W-1:0] dest,
        input logic [REG_IDX_W-1:0] src
    );
        return wb_en && (dest == src) && (src != PC_REG);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational RAW-hazard detector between the ID stage and the EX/MEM stages.
// With forwarding present only a load in EX can force a stall (load-use);
// without forwarding any pending write in EX or MEM stalls the consumer.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic [REG_IDX_W-1:0] ex_dest,
    input  logic                 ex_wb_en,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    output logic                 hazard
);

    logic m1;
    logic m2;

    // Match ID sources against EX (m1) and MEM (m2) destinations, then apply
    // the stall policy selected by the forwarding option.
    always_comb begin
        m1     = 1'b0;
        m2     = 1'b0;
        hazard = 1'b0;
        if (id_valid) begin
            m1 = src_match(ex_wb_en, ex_dest, id_src1)
                 || (id_two_src && src_match(ex_wb_en, ex_dest, id_src2));
            m2 = src_match(mem_wb_en, mem_dest, id_src1)
                 || (id_two_src && src_match(mem_wb_en, mem_dest, id_src2));
        end
        if (FWD_EN != 0) begin
            hazard = m1 && ex_mem_read;
        end else begin
            hazard = m1 || m2;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline controller: hazard/branch hold-and-flush generation, a
// memory-wait FSM that freezes the whole pipeline while data memory is busy,
// a sticky timeout error flag and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FWD_EN      = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic [REG_IDX_W-1:0] ex_dest,
    input  logic                 ex_wb_en,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    input  logic                 branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 freeze_if,
    output logic                 flush_ifid,
    output logic                 flush_idex,
    output logic                 freeze_all,
    output logic                 mem_err,
    output logic [CNT_W-1:0]     stall_cycles
);

    // Timer counts 1..MEM_TIMEOUT-1 while waiting; one spare bit of headroom.
    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    mem_state_e       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             hazard;
    logic             mem_stall;
    pipe_ctrl_t       ctrl;

    hazard_detect #(
        .FWD_EN (FWD_EN)
    ) u_hazard_detect (
        .id_valid    (id_valid),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_two_src  (id_two_src),
        .ex_dest     (ex_dest),
        .ex_wb_en    (ex_wb_en),
        .ex_mem_read (ex_mem_read),
        .mem_dest    (mem_dest),
        .mem_wb_en   (mem_wb_en),
        .hazard      (hazard)
    );

    // State register: FSM state, wait timer, sticky error and stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            timer_q     <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state logic of the memory-wait FSM. The timer is preloaded with 1
    // on entry so the RUN cycle that starts the wait counts toward the
    // timeout; the abort cycle itself is still a frozen cycle.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        mem_err_d = mem_err_q;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d = MEM_WAIT;
                    timer_d = TMR_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                    timer_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    state_d   = RUN;
                    timer_d   = '0;
                    mem_err_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                timer_d = '0;
            end
        endcase
    end

    // Output logic: memory stall outranks a taken branch, which outranks a
    // RAW hazard. A frozen pipeline must not flush, or the branch target and
    // the held instructions would be lost while memory is busy.
    always_comb begin
        mem_stall = ((state_q == RUN) && mem_req && !mem_ready)
                    || ((state_q == MEM_WAIT) && !mem_ready);
        ctrl = '0;
        if (mem_stall) begin
            ctrl.freeze_all = 1'b1;
            ctrl.freeze_if  = 1'b1;
        end else if (branch_taken) begin
            ctrl.flush_ifid = 1'b1;
            ctrl.flush_idex = 1'b1;
        end else if (hazard) begin
            ctrl.freeze_if  = 1'b1;
            ctrl.flush_idex = 1'b1;
        end
    end

    // Stall counter: count every cycle in which anything is held, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((ctrl.freeze_if || ctrl.freeze_all) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign freeze_if    = ctrl.freeze_if;
    assign flush_ifid   = ctrl.flush_ifid;
    assign flush_idex   = ctrl.flush_idex;
    assign freeze_all   = ctrl.freeze_all;
    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl. Instance A: FWD_EN=1, MEM_TIMEOUT=4,
// CNT_W=4. Instance B: FWD_EN=0 (defaults otherwise), hazard inputs shared,
// memory port tied idle.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       id_valid;
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_two_src;
    logic [3:0] ex_dest;
    logic       ex_wb_en;
    logic       ex_mem_read;
    logic [3:0] mem_dest;
    logic       mem_wb_en;
    logic       branch_taken;
    logic       mem_req;
    logic       mem_ready;

    logic       a_freeze_if, a_flush_ifid, a_flush_idex, a_freeze_all, a_mem_err;
    logic [3:0] a_stall_cycles;
    logic       b_freeze_if, b_flush_ifid, b_flush_idex, b_freeze_all, b_mem_err;
    logic [15:0] b_stall_cycles;

    pipe_hazard_ctrl #(
        .FWD_EN      (1),
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .ex_dest      (ex_dest),
        .ex_wb_en     (ex_wb_en),
        .ex_mem_read  (ex_mem_read),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .freeze_if    (a_freeze_if),
        .flush_ifid   (a_flush_ifid),
        .flush_idex   (a_flush_idex),
        .freeze_all   (a_freeze_all),
        .mem_err      (a_mem_err),
        .stall_cycles (a_stall_cycles)
    );

    pipe_hazard_ctrl #(
        .FWD_EN      (0),
        .MEM_TIMEOUT (64),
        .CNT_W       (16)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .ex_dest      (ex_dest),
        .ex_wb_en     (ex_wb_en),
        .ex_mem_read  (ex_mem_read),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .branch_taken (branch_taken),
        .mem_req      (1'b0),
        .mem_ready    (1'b0),
        .freeze_if    (b_freeze_if),
        .flush_ifid   (b_flush_ifid),
        .flush_idex   (b_flush_idex),
        .freeze_all   (b_freeze_all),
        .mem_err      (b_mem_err),
        .stall_cycles (b_stall_cycles)
    );

    // ea = {freeze_if, flush_ifid, flush_idex, freeze_all, mem_err} of A
    // eb = {freeze_if, flush_ifid, flush_idex, freeze_all} of B
    typedef struct packed {
        logic [4:0] ea;
        logic [3:0] ecnt;
        logic       chk_b;
        logic [3:0] eb;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];
    int    n_cmp   = 0;
    int    n_bad   = 0;
    int    exp_cnt = 0;

    // Queue one expectation for the current cycle, update the expected stall
    // count from the hand-given freeze bits, then advance one cycle.
    task automatic drive(input string nm, input logic [4:0] ea,
                         input logic cb, input logic [3:0] eb);
        exp_t it;
        it.ea    = ea;
        it.ecnt  = 4'(exp_cnt);
        it.chk_b = cb;
        it.eb    = eb;
        sb_q.push_back(it);
        name_q.push_back(nm);
        if (rst && (ea[4] || ea[1])) exp_cnt = (exp_cnt >= 15) ? 15 : exp_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop one expectation per cycle, sampled on the falling edge.
    exp_t       mon_it;
    string      mon_nm;
    logic [4:0] mon_a;
    logic [3:0] mon_b;
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_it = sb_q.pop_front();
            mon_nm = name_q.pop_front();
            mon_a  = {a_freeze_if, a_flush_ifid, a_flush_idex, a_freeze_all, a_mem_err};
            mon_b  = {b_freeze_if, b_flush_ifid, b_flush_idex, b_freeze_all};
            n_cmp++;
            if (mon_a !== mon_it.ea) begin
                n_bad++;
                $display("FAIL %s ctrl_a: got %b want %b", mon_nm, mon_a, mon_it.ea);
            end
            n_cmp++;
            if (a_stall_cycles !== mon_it.ecnt) begin
                n_bad++;
                $display("FAIL %s stall_cycles_a: got %0d want %0d", mon_nm, a_stall_cycles, mon_it.ecnt);
            end
            if (mon_it.chk_b) begin
                n_cmp++;
                if (mon_b !== mon_it.eb) begin
                    n_bad++;
                    $display("FAIL %s ctrl_b: got %b want %b", mon_nm, mon_b, mon_it.eb);
                end
            end
            $display("[%0t] %s a=%b cnt=%0d b=%b", $time, mon_nm, mon_a, a_stall_cycles, mon_b);
        end
    end

    initial begin
        rst = 1'b0; id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_two_src = 1'b0;
        ex_dest = '0; ex_wb_en = 1'b0; ex_mem_read = 1'b0; mem_dest = '0; mem_wb_en = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        drive("reset_idle", 5'b00000, 1'b1, 4'b0000);
        rst = 1'b1;

        // 1: load-use on src1
        id_valid = 1'b1; id_src1 = 4'd3; ex_dest = 4'd3; ex_wb_en = 1'b1; ex_mem_read = 1'b1;
        drive("load_use_src1", 5'b10100, 1'b1, 4'b1010);
        ex_mem_read = 1'b0;
        drive("alu_raw_fwd", 5'b00000, 1'b1, 4'b1010);
        id_src1 = 4'd15; ex_dest = 4'd15; ex_mem_read = 1'b1;
        drive("pc_source", 5'b00000, 1'b1, 4'b0000);
        id_valid = 1'b0; id_src1 = 4'd3; ex_dest = 4'd3;
        drive("id_bubble", 5'b00000, 1'b1, 4'b0000);

        // 2: MEM-stage dependency through src2
        id_valid = 1'b1; id_src1 = 4'd0; ex_wb_en = 1'b0; ex_mem_read = 1'b0; ex_dest = 4'd0;
        mem_wb_en = 1'b1; mem_dest = 4'd5; id_two_src = 1'b1; id_src2 = 4'd5;
        drive("mem_raw_src2", 5'b00000, 1'b1, 4'b1010);
        id_two_src = 1'b0;
        drive("mem_raw_one_src", 5'b00000, 1'b1, 4'b0000);
        id_two_src = 1'b1; mem_wb_en = 1'b0; ex_wb_en = 1'b1; ex_dest = 4'd5; ex_mem_read = 1'b1;
        drive("load_use_src2", 5'b10100, 1'b1, 4'b1010);

        // 3: branch beats hazard
        branch_taken = 1'b1;
        drive("branch_over_haz", 5'b01100, 1'b1, 4'b0110);
        id_valid = 1'b0; ex_wb_en = 1'b0; ex_mem_read = 1'b0; branch_taken = 1'b0; id_two_src = 1'b0;

        // 4: three wait cycles then ready; branch ignored while frozen
        mem_req = 1'b1; mem_ready = 1'b0;
        drive("mem_wait0", 5'b10010, 1'b0, 4'b0000);
        branch_taken = 1'b1;
        drive("mem_wait1_br", 5'b10010, 1'b0, 4'b0000);
        drive("mem_wait2_br", 5'b10010, 1'b0, 4'b0000);
        branch_taken = 1'b0; mem_ready = 1'b1;
        drive("mem_ready", 5'b00000, 1'b0, 4'b0000);
        mem_req = 1'b0; mem_ready = 1'b0;
        drive("back_in_run", 5'b00000, 1'b0, 4'b0000);
        mem_req = 1'b1; mem_ready = 1'b1;
        drive("zero_wait", 5'b00000, 1'b0, 4'b0000);

        // 5: timeout after 4 frozen cycles
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive("timeout_wait", 5'b10010, 1'b0, 4'b0000);
        mem_req = 1'b0;
        drive("timeout_err", 5'b00001, 1'b0, 4'b0000);
        drive("err_sticky", 5'b00001, 1'b1, 4'b0000);

        // Saturation: persistent load-use hazard
        id_valid = 1'b1; id_src1 = 4'd7; ex_dest = 4'd7; ex_wb_en = 1'b1; ex_mem_read = 1'b1;
        for (int i = 0; i < 12; i++) drive("sat_haz", 5'b10101, 1'b1, 4'b1010);
        id_valid = 1'b0; ex_wb_en = 1'b0; ex_mem_read = 1'b0;

        // 6: reset while in MEM_WAIT
        mem_req = 1'b1; mem_ready = 1'b0;
        drive("wait_enter", 5'b10011, 1'b0, 4'b0000);
        drive("wait_hold", 5'b10011, 1'b0, 4'b0000);
        rst = 1'b0; exp_cnt = 0;
        drive("rst_req_high", 5'b10010, 1'b0, 4'b0000);
        mem_req = 1'b0;
        drive("rst_req_low", 5'b00000, 1'b0, 4'b0000);
        rst = 1'b1;
        id_valid = 1'b1; id_src1 = 4'd2; ex_dest = 4'd2; ex_wb_en = 1'b1; ex_mem_read = 1'b1;
        drive("post_rst_haz", 5'b10100, 1'b1, 4'b1010);
        id_valid = 1'b0;
        drive("post_rst_idle", 5'b00000, 1'b1, 4'b0000);

        @(posedge clk); #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
